// File: rtl/game_pkg.sv
// Shared types and widths for the falling-object game logic.
package game_pkg;

  localparam int POS_W   = 11;
  localparam int SCORE_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_LOAD,
    S_FALL,
    S_JUDGE,
    S_OVER
  } judge_state_t;

endpackage

// File: rtl/catch_window.sv
// Combinational catch test: |a - b| <= HALF_W, evaluated as a signed
// POS_W+1 difference so positions near either screen edge never wrap.
module catch_window
  import game_pkg::*;
#(
  parameter int HALF_W = 32
) (
  input  logic [POS_W-1:0] i_a,
  input  logic [POS_W-1:0] i_b,
  output logic             o_in_window
);

  logic signed [POS_W:0] w_diff;
  logic        [POS_W:0] w_abs;

  assign w_diff      = signed'({1'b0, i_a}) - signed'({1'b0, i_b});
  assign w_abs       = w_diff[POS_W] ? unsigned'(-w_diff) : unsigned'(w_diff);
  assign o_in_window = (w_abs <= (POS_W + 1)'(HALF_W));

endmodule

// File: rtl/catch_judge.sv
// Game-rule engine: requests objects, drops them on the fall-rate strobe,
// and judges catch/miss at the floor line while tracking score and lives.
module catch_judge
  import game_pkg::*;
#(
  parameter int Y_W          = 10,
  parameter int FLOOR_Y      = 480,
  parameter int FALL_STEP    = 4,
  parameter int CATCH_HALF_W = 32,
  parameter int LIVES        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [POS_W-1:0]   object_position,
  input  logic [POS_W-1:0]   player_position,
  output logic               respawn,
  output logic [POS_W-1:0]   obj_x,
  output logic [Y_W-1:0]     obj_y,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  judge_state_t r_state, w_next_state;

  logic               r_respawn, r_hit, r_miss, r_game_over;
  logic [POS_W-1:0]   r_obj_x;
  logic [Y_W-1:0]     r_obj_y;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_lives;

  logic [Y_W:0] w_y_sum;
  logic         w_land, w_in_window, w_game_start;
  logic         w_respawn_d, w_hit_d, w_miss_d, w_game_over_d;

  catch_window #(.HALF_W(CATCH_HALF_W)) u_window (
    .i_a         (r_obj_x),
    .i_b         (player_position),
    .o_in_window (w_in_window)
  );

  assign w_y_sum      = {1'b0, r_obj_y} + (Y_W + 1)'(FALL_STEP);
  assign w_land       = (r_state == S_FALL) && tick && (w_y_sum >= (Y_W + 1)'(FLOOR_Y));
  assign w_game_start = start && ((r_state == S_IDLE) || (r_state == S_OVER));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves w_next_state unassigned
  // and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next_state = S_SPAWN;
      S_SPAWN: w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_FALL;
      S_FALL:  if (w_land) w_next_state = S_JUDGE;
      // Lives were already decremented on entry, so zero means the last one went.
      S_JUDGE: w_next_state = (r_miss && (r_lives == 2'd0)) ? S_OVER : S_SPAWN;
      S_OVER:  if (start) w_next_state = S_SPAWN;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The verdict is taken on the edge entering JUDGE so the pulse is visible
  // during the JUDGE cycle itself.
  always_comb begin
    w_respawn_d   = (w_next_state == S_SPAWN);
    w_hit_d       = w_land && w_in_window;
    w_miss_d      = w_land && !w_in_window;
    w_game_over_d = (w_next_state == S_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_respawn   <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
      r_obj_x     <= '0;
      r_obj_y     <= '0;
      r_score     <= '0;
      r_lives     <= 2'(LIVES);
    end else begin
      r_respawn   <= w_respawn_d;
      r_hit       <= w_hit_d;
      r_miss      <= w_miss_d;
      r_game_over <= w_game_over_d;

      if (w_game_start) begin
        r_score <= '0;
        r_lives <= 2'(LIVES);
      end else begin
        if (w_hit_d && (r_score != '1)) r_score <= r_score + 1'b1;
        if (w_miss_d)                   r_lives <= r_lives - 2'd1;
      end

      if (r_state == S_LOAD) begin
        r_obj_x <= object_position;
        r_obj_y <= '0;
      end else if ((r_state == S_FALL) && tick) begin
        r_obj_y <= w_land ? Y_W'(FLOOR_Y) : w_y_sum[Y_W-1:0];
      end
    end
  end

  assign respawn   = r_respawn;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign game_over = r_game_over;
  assign obj_x     = r_obj_x;
  assign obj_y     = r_obj_y;
  assign score     = r_score;
  assign lives     = r_lives;

endmodule

// File: tb/tb_catch_judge.sv
// Scoreboard bench for catch_judge: expected pulse events are queued by the
// stimulus and popped by an independent monitor on the falling edge.
module tb_catch_judge;
  import game_pkg::*;

  typedef enum int {EV_RESPAWN = 0, EV_HIT = 1, EV_MISS = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       score;
    int       lives;
  } ev_t;

  logic               clk = 1'b0;
  logic               rst, start, tick;
  logic [POS_W-1:0]   object_position, player_position;
  logic               respawn, hit, miss, game_over;
  logic [POS_W-1:0]   obj_x;
  logic [9:0]         obj_y;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];

  catch_judge dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .tick            (tick),
    .object_position (object_position),
    .player_position (player_position),
    .respawn         (respawn),
    .obj_x           (obj_x),
    .obj_y           (obj_y),
    .hit             (hit),
    .miss            (miss),
    .score           (score),
    .lives           (lives),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input int s, input int l);
    ev_t e;
    e.kind  = k;
    e.score = s;
    e.lives = l;
    exp_q.push_back(e);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  // JUDGE -> SPAWN -> LOAD -> FALL
  task automatic next_object();
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_respawn"},   respawn,   0);
    check({tag, "_hit"},       hit,       0);
    check({tag, "_miss"},      miss,      0);
    check({tag, "_obj_x"},     obj_x,     0);
    check({tag, "_obj_y"},     obj_y,     0);
    check({tag, "_score"},     score,     0);
    check({tag, "_lives"},     lives,     3);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  // Monitor: every respawn/hit/miss pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && (respawn || hit || miss)) begin
      check("pulse_exclusive", 32'(respawn) + 32'(hit) + 32'(miss), 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got r=%0b h=%0b m=%0b expected none (t=%0t)",
                 respawn, hit, miss, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_kind", hit ? EV_HIT : (miss ? EV_MISS : EV_RESPAWN), e.kind);
        check("ev_score", score, e.score);
        check("ev_lives", lives, e.lives);
        if (hit || miss) check("ev_judge_obj_y", obj_y, 480);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    start           = 1'b0;
    tick            = 1'b0;
    object_position = 11'd100;
    player_position = 11'd120;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Start and spawn
    push(EV_RESPAWN, 0, 3);
    pulse_start();
    check("spawn_respawn", respawn, 1);
    @(negedge clk);
    check("spawn_respawn_one_cycle", respawn, 0);
    @(negedge clk);
    check("load_obj_x", obj_x, 100);
    check("load_obj_y", obj_y, 0);

    // Fall and catch, |d| = 20
    push(EV_HIT, 1, 3);
    push(EV_RESPAWN, 1, 3);
    do_ticks(119);
    check("fall_obj_y_476", obj_y, 476);
    do_ticks(1);
    check("catch_hit", hit, 1);
    check("catch_score", score, 1);
    next_object();

    // Boundary: |d| = 32 is a hit
    player_position = 11'd132;
    push(EV_HIT, 2, 3);
    push(EV_RESPAWN, 2, 3);
    do_ticks(120);
    check("edge32_hit", hit, 1);
    next_object();

    // Boundary: |d| = 33 is a miss
    player_position = 11'd133;
    push(EV_MISS, 2, 2);
    push(EV_RESPAWN, 2, 2);
    do_ticks(120);
    check("edge33_miss", miss, 1);
    check("edge33_lives", lives, 2);
    object_position = 11'd10;
    next_object();
    check("wrap_obj_x", obj_x, 10);

    // Wrap safety: x=10 vs player 2040 must miss
    player_position = 11'd2040;
    push(EV_MISS, 2, 1);
    push(EV_RESPAWN, 2, 1);
    do_ticks(120);
    check("wrap_miss", miss, 1);
    next_object();

    // Final miss -> game over, no respawn
    push(EV_MISS, 2, 0);
    do_ticks(120);
    @(negedge clk);
    check("over_game_over", game_over, 1);
    check("over_lives", lives, 0);
    do_ticks(5);
    check("over_tick_ignored_y", obj_y, 480);
    check("over_holds", game_over, 1);

    // Restart from OVER
    object_position = 11'd300;
    push(EV_RESPAWN, 0, 3);
    pulse_start();
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);
    check("restart_game_over", game_over, 0);
    @(negedge clk);
    @(negedge clk);
    check("restart_obj_x", obj_x, 300);

    // start mid-fall is ignored
    do_ticks(50);
    check("midfall_obj_y", obj_y, 200);
    pulse_start();
    check("midfall_start_ignored_y", obj_y, 200);
    check("midfall_start_ignored_score", score, 0);

    // Asynchronous reset mid-fall
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    do_ticks(5);
    check("idle_tick_ignored_y", obj_y, 0);
    check("idle_no_respawn", respawn, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
